// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Byte-addressable data memory for the RV32 load/store unit. It uses a
//   req/ack handshake with a programmable number of wait states. It supports
//   the RV32 access sizes, steers data onto the correct byte lanes, and applies
//   sign or zero extension to loads.
//
// Parameters
//   AW           word-address width; depth = 2**AW 32-bit words
//   WAIT_CYCLES  extra wait cycles per access (0..15)
//   CLEAR_ON_RST 1 = every word is cleared by reset, 0 = array is not reset
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   Defined   : misaligned half/word accesses and size 2'b11 report err_o.
//               Such accesses write nothing and return rdata_o = 0.
//   Undefined : err_o is tied to 0. Misaligned low address bits are ignored,
//               and size 2'b11 is treated as a word access.
//
// Ports
//   clk_i       clock (rising edge)
//   rst_i       asynchronous reset, active-low
//   req_i       access request, sampled only in IDLE
//   we_i        1 = store, 0 = load
//   addr_i      byte address [AW+1:0]
//   size_i      00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i  1 = zero-extend load, 0 = sign-extend load
//   wdata_i     right-aligned store data
//   rdata_o     formatted load data; holds until the next access
//   ack_o       one-cycle completion strobe
//   busy_o      controller not in IDLE (registered)
//   err_o       access error; qualified by ack_o
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int AW           = 5,
  parameter int WAIT_CYCLES  = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW+1:0] addr_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  output logic          ack_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int         DEPTH    = 2 ** AW;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_we;
  logic           r_uns;
  logic [AW+1:0]  r_addr;
  logic [1:0]     r_size;
  logic [31:0]    r_wdata;
  logic [31:0]    r_rdata;
  logic           r_ack;
  logic           r_busy;
  logic           r_err;

  // Effective access attributes. With zero wait states, the access happens
  // on the accepting edge itself, so the live inputs must be used. In every
  // other case, the values latched at acceptance are used.
  logic           w_in_idle;
  logic           w_fire;
  logic           w_we;
  logic           w_uns;
  logic [AW+1:0]  w_addr;
  logic [1:0]     w_size;
  logic [31:0]    w_wdata;
  logic [AW-1:0]  w_word_idx;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_we       = w_in_idle ? we_i       : r_we;
  assign w_uns      = w_in_idle ? unsigned_i : r_uns;
  assign w_addr     = w_in_idle ? addr_i     : r_addr;
  assign w_size     = w_in_idle ? size_i     : r_size;
  assign w_wdata    = w_in_idle ? wdata_i    : r_wdata;
  assign w_word_idx = w_addr[AW+1:2];

  // Access edge: this is the edge that enters ACK. It is gated by rst_i so
  // that no write can slip into the array while reset is held.
  assign w_fire = rst_i &&
                  ((w_in_idle && req_i && NO_WAIT) ||
                   ((r_state == ST_WAIT) && (r_cnt == 4'd0)));

  // ---------------------------------------------------------------------------
  // Error detection and byte-lane enables
  // ---------------------------------------------------------------------------
  logic       w_err;
  logic [3:0] w_be_raw;
  logic [3:0] w_be;
  logic [31:0] w_wlanes;
  logic        w_mem_we;

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_err = ((w_size == 2'b01) && w_addr[0]) ||
                 ((w_size == 2'b10) && (w_addr[1:0] != 2'b00)) ||
                 (w_size == 2'b11);
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_be_raw = 4'b1111;
    w_wlanes = w_wdata;
    case (w_size)
      2'b00: begin
        w_be_raw = 4'b0001 << w_addr[1:0];
        w_wlanes = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        // Only addr[1] picks the half; addr[0] is ignored or flagged by w_err.
        w_be_raw = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be_raw = 4'b1111;
        w_wlanes = w_wdata;
      end
    endcase
  end

  assign w_be     = w_err ? 4'b0000 : w_be_raw;
  assign w_mem_we = w_fire && w_we;

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane, so each lane has its own write enable.
  // ---------------------------------------------------------------------------
  logic [31:0] w_rword;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      if (CLEAR_ON_RST != 0) begin : g_clr
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
              r_mem[i] <= 8'h00;
            end
          end else if (w_mem_we && w_be[gi]) begin
            r_mem[w_word_idx] <= w_wlanes[gi*8 +: 8];
          end
        end
      end else begin : g_noclr
        always_ff @(posedge clk_i) begin
          if (w_mem_we && w_be[gi]) begin
            r_mem[w_word_idx] <= w_wlanes[gi*8 +: 8];
          end
        end
      end

      assign w_rword[gi*8 +: 8] = r_mem[w_word_idx];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load formatting: move the selected byte or half to bit 0, then extend it.
  // ---------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_byte = w_rword[{w_addr[1:0], 3'b000} +: 8];
  assign w_half = w_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = w_rword;
    case (w_size)
      2'b00:   w_load = w_uns ? {24'h000000, w_byte}
                              : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_uns ? {16'h0000, w_half}
                              : {{16{w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_uns   <= unsigned_i;
            r_addr  <= addr_i;
            r_size  <= size_i;
            r_wdata <= wdata_i;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= NO_WAIT ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Stores and errored accesses return zero. Loads return the formatted word.
      if (w_fire) begin
        r_ack   <= 1'b1;
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? 32'h0 : w_load;
      end
    end
  end

  assign rdata_o = r_rdata;
  assign ack_o   = r_ack;
  assign busy_o  = r_busy;
  assign err_o   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int AW = 5;
  localparam int WAIT_CYCLES = 2;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          we_i;
  logic [AW+1:0] addr_i;
  logic [1:0]    size_i;
  logic          unsigned_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          ack_o;
  logic          busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_ctrl #(
    .AW           (AW),
    .WAIT_CYCLES  (WAIT_CYCLES),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Issues one request. The caller must be at a negedge; the task returns at a
  // negedge with the controller idle again.
  task automatic access(input string tag, input logic we, input logic [AW+1:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic exp_err, output logic [31:0] rdata);
    int n;
    int busy_n;
    bit got;
    req_i = 1'b1; we_i = we; addr_i = addr; size_i = size;
    unsigned_i = uns; wdata_i = wdata;
    got = 1'b0; busy_n = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      n++;
      if (n == 1) req_i = 1'b0;
      if (busy_o) busy_n++;
      if (ack_o) got = 1'b1;
    end
    check({tag, "_latency"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'd3);
    check({tag, "_busy"}, 32'(busy_n), 32'd3);
    check({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    rdata = rdata_o;
    @(negedge clk_i);
    check({tag, "_ack_single"}, {31'b0, ack_o}, 32'd0);
    $display("txn %-10s we=%0b addr=0x%02h size=%0d uns=%0b wdata=0x%08h -> rdata=0x%08h err=%0b",
             tag, we, addr, size, uns, wdata, rdata, exp_err);
  endtask

  initial begin
    logic [31:0] rd;
    int acks;

    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0;
    size_i = 2'b00; unsigned_i = 1'b0; wdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check("rst_ack",   {31'b0, ack_o},  32'd0);
    check("rst_busy",  {31'b0, busy_o}, 32'd0);
    check("rst_err",   {31'b0, err_o},  32'd0);
    check("rst_rdata", rdata_o,         32'd0);
    @(negedge clk_i);

    // Memory is cleared by reset.
    access("lw0", 1'b0, 7'h00, 2'b10, 1'b0, 32'h0, 1'b0, rd);
    check("lw0_data", rd, 32'h0000_0000);

    // Sign and zero extension.
    access("sw4", 1'b1, 7'h04, 2'b10, 1'b0, 32'h8000_00F2, 1'b0, rd);
    access("lb4", 1'b0, 7'h04, 2'b00, 1'b0, 32'h0, 1'b0, rd);
    check("lb4_data", rd, 32'hFFFF_FFF2);
    access("lbu4", 1'b0, 7'h04, 2'b00, 1'b1, 32'h0, 1'b0, rd);
    check("lbu4_data", rd, 32'h0000_00F2);
    access("lh6", 1'b0, 7'h06, 2'b01, 1'b0, 32'h0, 1'b0, rd);
    check("lh6_data", rd, 32'hFFFF_8000);
    access("lhu6", 1'b0, 7'h06, 2'b01, 1'b1, 32'h0, 1'b0, rd);
    check("lhu6_data", rd, 32'h0000_8000);
    access("lh4", 1'b0, 7'h04, 2'b01, 1'b0, 32'h0, 1'b0, rd);
    check("lh4_data", rd, 32'h0000_00F2);
    access("lb7", 1'b0, 7'h07, 2'b00, 1'b0, 32'h0, 1'b0, rd);
    check("lb7_data", rd, 32'hFFFF_FF80);

    // Byte store merges into an existing word.
    access("sw8", 1'b1, 7'h08, 2'b10, 1'b0, 32'h1122_3344, 1'b0, rd);
    access("sb9", 1'b1, 7'h09, 2'b00, 1'b0, 32'h0000_00AB, 1'b0, rd);
    access("lw8", 1'b0, 7'h08, 2'b10, 1'b0, 32'h0, 1'b0, rd);
    check("lw8_data", rd, 32'h1122_AB44);
    access("lw4", 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, 1'b0, rd);
    check("lw4_data", rd, 32'h8000_00F2);
    access("lw0b", 1'b0, 7'h00, 2'b10, 1'b0, 32'h0, 1'b0, rd);
    check("lw0b_data", rd, 32'h0000_0000);

    // req_i held high: one ack per access, next accept at edge k+4.
    req_i = 1'b1; we_i = 1'b1; addr_i = 7'h0C; size_i = 2'b10;
    unsigned_i = 1'b0; wdata_i = 32'h5566_7788;
    acks = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
      if (i == 3) check("hold_busy_k2", {31'b0, busy_o}, 32'd1);
    end
    check("hold_idle_k3", {31'b0, busy_o}, 32'd0);
    check("hold_acks", 32'(acks), 32'd1);
    we_i = 1'b0; wdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("hold_accept_k4", {31'b0, busy_o}, 32'd1);
    req_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    check("hold_ld_ack", 32'(acks), 32'd1);
    check("hold_ld_data", rdata_o, 32'h5566_7788);
    $display("txn hold       sw+lw addr=0x0C -> rdata=0x%08h", rdata_o);
    @(negedge clk_i);

    // Reset during WAIT aborts the store.
    req_i = 1'b1; we_i = 1'b1; addr_i = 7'h10; size_i = 2'b10; wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    req_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    check("abort_ack",   {31'b0, ack_o},  32'd0);
    check("abort_busy",  {31'b0, busy_o}, 32'd0);
    check("abort_err",   {31'b0, err_o},  32'd0);
    check("abort_rdata", rdata_o,         32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    $display("txn abort      sw addr=0x10 interrupted by reset");
    access("lw10", 1'b0, 7'h10, 2'b10, 1'b0, 32'h0, 1'b0, rd);
    check("lw10_data", rd, 32'h0000_0000);

    // Misaligned half store.
    access("sw0", 1'b1, 7'h00, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, rd);
    access("sh3", 1'b1, 7'h03, 2'b01, 1'b0, 32'h0000_1234, MISALIGN_EN, rd);
    check("sh3_rdata", rd, 32'h0000_0000);
    access("lw0c", 1'b0, 7'h00, 2'b10, 1'b0, 32'h0, 1'b0, rd);
    check("lw0c_data", rd, MISALIGN_EN ? 32'hCAFE_F00D : 32'h1234_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
